// File: rtl/decode_ctrl_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage_pkg
// Shared definitions for the RV32 ID-stage controller:
//   - base opcode constants and the funct3/funct7 codes the decoder inspects
//   - ImmSel / ALUop encodings and Br_Mask bit positions
//   - FSM state type and the packed ID/EX control bundle
// No ports; imported by ctrl_decode_comb and decode_ctrl_stage.
// ---------------------------------------------------------------------------
package decode_ctrl_stage_pkg;

   // Base opcodes (instr[6:0])
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Branch funct3 codes
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // funct7 marking an M-extension op inside the OP opcode
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Immediate format select
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   // ALU operation class
   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP     = 2'b01;
   localparam logic [1:0] ALU_OP_IMM = 2'b10;

   // Br_Mask bit positions
   localparam int BR_BEQ  = 0;
   localparam int BR_BLT  = 1;
   localparam int BR_BNE  = 2;
   localparam int BR_BGE  = 3;
   localparam int BR_BLTU = 4;
   localparam int BR_BGEU = 5;
   localparam int BR_JALR = 6;
   localparam int BR_JAL  = 7;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_e;

   // ID/EX control bundle
   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       lui;
      logic       auipc;
      logic       imme;
      logic       mdu;
      logic [2:0] mem_mode;
      logic [2:0] imm_sel;
      logic [2:0] mdu_op;
      logic [1:0] alu_op;
      logic [7:0] br_mask;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_comb.sv
// ---------------------------------------------------------------------------
// ctrl_decode_comb
// Purely combinational RV32I(+M) opcode/funct decoder.
// Ports:
//   i_instr     in  32  instruction word
//   o_ctrl      out     decoded control bundle (valid=1 always; illegal marked)
//   o_rs1_used  out  1  instruction reads rs1
//   o_rs2_used  out  1  instruction reads rs2
// ---------------------------------------------------------------------------
module ctrl_decode_comb
   import decode_ctrl_stage_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0] i_instr,
   output ctrl_t       o_ctrl,
   output logic        o_rs1_used,
   output logic        o_rs2_used
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       illegal;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];
   assign funct7 = i_instr[31:25];

   always_comb begin
      o_ctrl          = CTRL_BUBBLE;
      o_rs1_used      = 1'b0;
      o_rs2_used      = 1'b0;
      illegal         = 1'b0;

      o_ctrl.valid     = 1'b1;
      o_ctrl.rd        = i_instr[11:7];
      o_ctrl.rs1       = i_instr[19:15];
      o_ctrl.rs2       = i_instr[24:20];
      o_ctrl.mem_mode  = funct3;
      o_ctrl.reg_write = 1'b1;
      o_ctrl.imme      = 1'b1;
      o_ctrl.imm_sel   = IMM_I;
      o_ctrl.alu_op    = ALU_ADD;

      case (opcode)
         OPC_LOAD: begin
            o_ctrl.mem_read   = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_rs1_used        = 1'b1;
         end
         OPC_STORE: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.reg_write = 1'b0;
            o_ctrl.imm_sel   = IMM_S;
            o_rs1_used       = 1'b1;
            o_rs2_used       = 1'b1;
         end
         OPC_BRANCH: begin
            o_ctrl.reg_write = 1'b0;
            o_ctrl.imm_sel   = IMM_B;
            o_rs1_used       = 1'b1;
            o_rs2_used       = 1'b1;
            // funct3 010/011 are not branch conditions: decoded with an empty mask
            case (funct3)
               F3_BEQ:  o_ctrl.br_mask[BR_BEQ]  = 1'b1;
               F3_BNE:  o_ctrl.br_mask[BR_BNE]  = 1'b1;
               F3_BLT:  o_ctrl.br_mask[BR_BLT]  = 1'b1;
               F3_BGE:  o_ctrl.br_mask[BR_BGE]  = 1'b1;
               F3_BLTU: o_ctrl.br_mask[BR_BLTU] = 1'b1;
               F3_BGEU: o_ctrl.br_mask[BR_BGEU] = 1'b1;
               default: o_ctrl.br_mask          = 8'h00;
            endcase
         end
         OPC_JAL: begin
            o_ctrl.imm_sel         = IMM_J;
            o_ctrl.br_mask[BR_JAL] = 1'b1;
         end
         OPC_JALR: begin
            o_ctrl.br_mask[BR_JALR] = 1'b1;
            o_rs1_used              = 1'b1;
         end
         OPC_OP: begin
            o_ctrl.imme   = 1'b0;
            o_ctrl.alu_op = ALU_OP;
            o_rs1_used    = 1'b1;
            o_rs2_used    = 1'b1;
            if (funct7 == FUNCT7_MULDIV) begin
               if (ENABLE_M) begin
                  o_ctrl.mdu    = 1'b1;
                  o_ctrl.mdu_op = funct3;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         OPC_OP_IMM: begin
            o_ctrl.alu_op = ALU_OP_IMM;
            o_rs1_used    = 1'b1;
         end
         OPC_LUI: begin
            o_ctrl.lui     = 1'b1;
            o_ctrl.imm_sel = IMM_U;
         end
         OPC_AUIPC: begin
            o_ctrl.auipc   = 1'b1;
            o_ctrl.imm_sel = IMM_U;
         end
         default: illegal = 1'b1;
      endcase

      // Illegal instructions still occupy a slot (valid=1) so the trap logic
      // downstream sees them, but carry no side-effecting controls.
      if (illegal) begin
         o_ctrl         = CTRL_BUBBLE;
         o_ctrl.valid   = 1'b1;
         o_ctrl.illegal = 1'b1;
         o_ctrl.rd      = i_instr[11:7];
         o_ctrl.rs1     = i_instr[19:15];
         o_ctrl.rs2     = i_instr[24:20];
      end
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ---------------------------------------------------------------------------
// decode_ctrl_stage
// Registered ID stage controller: decode into the ID/EX control register,
// load-use hazard detection, MDU start/done sequencing with timeout,
// stall/flush handling.
// Ports:
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_Instr, i_valid           IF/ID instruction and its valid
//   i_stall, i_flush           downstream hold / branch kill
//   i_ex_MemRead, i_ex_rd      load-in-EX info for hazard detection
//   i_mdu_done                 MDU completion pulse
//   o_stall_fe                 combinational front-end hold
//   o_mdu_start, o_mdu_err     MDU launch pulse, sticky timeout flag
//   o_ctrl_*, o_illegal        registered control bundle
//   o_rd, o_rs1, o_rs2         registered register indices
// ---------------------------------------------------------------------------
module decode_ctrl_stage
   import decode_ctrl_stage_pkg::*;
#(
   parameter bit          ENABLE_M    = 1'b1,
   parameter int unsigned MDU_TIMEOUT = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_Instr,
   input  logic        i_valid,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_ex_MemRead,
   input  logic [4:0]  i_ex_rd,
   input  logic        i_mdu_done,
   output logic        o_stall_fe,
   output logic        o_mdu_start,
   output logic        o_mdu_err,
   output logic        o_ctrl_valid,
   output logic        o_illegal,
   output logic        o_ctrl_MemRead,
   output logic        o_ctrl_MemWrite,
   output logic        o_ctrl_RegWrite,
   output logic        o_ctrl_MemToReg,
   output logic        o_ctrl_LUI,
   output logic        o_ctrl_AUIPC,
   output logic        o_ctrl_Imme,
   output logic        o_ctrl_MDU,
   output logic [2:0]  o_ctrl_Mem_Mode,
   output logic [2:0]  o_ctrl_ImmSel,
   output logic [2:0]  o_ctrl_MDU_op,
   output logic [1:0]  o_ctrl_ALUop,
   output logic [7:0]  o_ctrl_Br_Mask,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MDU_TIMEOUT);

   ctrl_t      dec_ctrl;
   logic       rs1_used;
   logic       rs2_used;

   ctrl_t      ctrl_q, ctrl_d;
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       mdu_start_q, mdu_start_d;

   logic       load_use;
   logic       mdu_busy;
   logic [7:0] cnt_inc;

   ctrl_decode_comb #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .i_instr    (i_Instr),
      .o_ctrl     (dec_ctrl),
      .o_rs1_used (rs1_used),
      .o_rs2_used (rs2_used)
   );

   assign load_use = i_valid & i_ex_MemRead & (i_ex_rd != 5'd0) &
                     ((rs1_used & (i_ex_rd == dec_ctrl.rs1)) |
                      (rs2_used & (i_ex_rd == dec_ctrl.rs2)));

   // The done cycle is not a busy cycle: the instruction waiting in IF/ID is
   // accepted on that edge, so a done k cycles after start costs k bubbles.
   assign mdu_busy   = (state_q == ST_MDU_WAIT) & ~i_mdu_done;
   assign o_stall_fe = (load_use | mdu_busy) & ~i_flush;
   assign cnt_inc    = cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      ctrl_d      = ctrl_q;
      mdu_start_d = 1'b0;

      if (!i_stall) begin
         // An in-flight MDU op keeps retiring even across a flush.
         if (state_q == ST_MDU_WAIT) begin
            cnt_d = cnt_inc;
            if (i_mdu_done) begin
               state_d = ST_RUN;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               err_d   = 1'b1;
               state_d = ST_RUN;
            end
         end

         if (i_flush || mdu_busy || load_use || !i_valid) begin
            ctrl_d = CTRL_BUBBLE;
         end else begin
            ctrl_d = dec_ctrl;
            if (dec_ctrl.mdu) begin
               mdu_start_d = 1'b1;
               state_d     = ST_MDU_WAIT;
               cnt_d       = 8'd0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl_q      <= CTRL_BUBBLE;
         state_q     <= ST_RUN;
         cnt_q       <= 8'd0;
         err_q       <= 1'b0;
         mdu_start_q <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         mdu_start_q <= mdu_start_d;
      end
   end

   assign o_mdu_start     = mdu_start_q;
   assign o_mdu_err       = err_q;
   assign o_ctrl_valid    = ctrl_q.valid;
   assign o_illegal       = ctrl_q.illegal;
   assign o_ctrl_MemRead  = ctrl_q.mem_read;
   assign o_ctrl_MemWrite = ctrl_q.mem_write;
   assign o_ctrl_RegWrite = ctrl_q.reg_write;
   assign o_ctrl_MemToReg = ctrl_q.mem_to_reg;
   assign o_ctrl_LUI      = ctrl_q.lui;
   assign o_ctrl_AUIPC    = ctrl_q.auipc;
   assign o_ctrl_Imme     = ctrl_q.imme;
   assign o_ctrl_MDU      = ctrl_q.mdu;
   assign o_ctrl_Mem_Mode = ctrl_q.mem_mode;
   assign o_ctrl_ImmSel   = ctrl_q.imm_sel;
   assign o_ctrl_MDU_op   = ctrl_q.mdu_op;
   assign o_ctrl_ALUop    = ctrl_q.alu_op;
   assign o_ctrl_Br_Mask  = ctrl_q.br_mask;
   assign o_rd            = ctrl_q.rd;
   assign o_rs1           = ctrl_q.rs1;
   assign o_rs2           = ctrl_q.rs2;

endmodule
